// File: rtl/seq_shift_unit_if.sv
// Operand/result handshake bundle for the multi-cycle shifter.
interface seq_shift_unit_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] In;
    logic [CNT_W-1:0] Cnt;
    logic [1:0]       Op;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] Out;
    logic             out_vld;
    logic             out_rdy;
    logic             busy;

    modport master (
        output In, Cnt, Op, in_vld, out_rdy,
        input  in_rdy, Out, out_vld, busy
    );

    modport slave (
        input  In, Cnt, Op, in_vld, out_rdy,
        output in_rdy, Out, out_vld, busy
    );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR applied up to STEP bits per cycle
// until the requested count is consumed, with valid/ready on both sides.
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input logic             clk,
    input logic             rst,
    seq_shift_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W:0] STEP_W = (CNT_W+1)'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] amt;
    logic [1:0]       op_q;

    function automatic logic [WIDTH-1:0] shift_fn(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] v,
        input logic [CNT_W-1:0] a
    );
        logic signed [WIDTH-1:0]   sv;
        logic        [2*WIDTH-1:0] dbl;
        logic        [WIDTH-1:0]   r;
        sv  = $signed(v);
        dbl = {v, v} >> a;
        case (op)
            2'b00:   r = v << a;
            2'b01:   r = v >> a;
            2'b10:   r = sv >>> a;
            default: r = dbl[WIDTH-1:0];
        endcase
        return r;
    endfunction

    // rem < WIDTH always, so when STEP is capped it fits in CNT_W bits
    always_comb begin
        amt = rem;
        if ({1'b0, rem} > STEP_W)
            amt = STEP_W[CNT_W-1:0];
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.in_vld) nxt = (bus.Cnt == '0) ? DONE : SHIFT;
            SHIFT:   if (rem == amt) nxt = DONE;
            DONE:    if (bus.out_rdy) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            rem   <= '0;
            op_q  <= 2'b00;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (bus.in_vld) begin
                        work <= bus.In;
                        rem  <= bus.Cnt;
                        op_q <= bus.Op;
                    end
                end
                SHIFT: begin
                    work <= shift_fn(op_q, work, amt);
                    rem  <= rem - amt;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_rdy  = (state == IDLE);
    assign bus.out_vld = (state == DONE);
    assign bus.busy    = (state != IDLE);
    assign bus.Out     = work;
endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (WIDTH=16, STEP=4).
module tb_seq_shift_unit;
    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seq_shift_unit_if #(.WIDTH(16)) bus ();

    seq_shift_unit #(.WIDTH(16), .STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!bus.in_rdy && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, 32'(bus.in_rdy), 32'd1);
    endtask

    // one full operation with out_rdy held high
    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] din,
                          input logic [3:0] cnt, input logic [15:0] exp, input int exp_lat);
        int lat;
        wait_rdy(tag);
        bus.out_rdy = 1'b1;
        bus.In      = din;
        bus.Cnt     = cnt;
        bus.Op      = op;
        bus.in_vld  = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        bus.In     = 16'hDEAD;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.out_vld && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_out"}, 32'(bus.Out), 32'(exp));
        tick();
        chk({tag, "_idle"}, {30'd0, bus.busy, bus.in_rdy}, 32'b01);
    endtask

    initial begin
        bus.In      = '0;
        bus.Cnt     = '0;
        bus.Op      = '0;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        tick();
        tick();
        chk("rst_ctl", {29'd0, bus.out_vld, bus.busy, bus.in_rdy}, 32'b001);
        chk("rst_out", 32'(bus.Out), 32'd0);
        rst = 1'b0;
        tick();

        run_op("sra_neg15",  SRA, 16'h8000, 4'd15, 16'hFFFF, 5);
        run_op("sra_pos3",   SRA, 16'h4000, 4'd3,  16'h0800, 2);
        run_op("sra_7fff",   SRA, 16'h7FFF, 4'd15, 16'h0000, 5);
        run_op("srl_15",     SRL, 16'h8000, 4'd15, 16'h0001, 5);
        run_op("sll_5",      SLL, 16'h0001, 4'd5,  16'h0020, 3);
        run_op("ror_4",      ROR, 16'h1234, 4'd4,  16'h4123, 2);
        run_op("ror_1",      ROR, 16'h0001, 4'd1,  16'h8000, 2);
        run_op("ror_15",     ROR, 16'h1234, 4'd15, 16'h2468, 5);
        run_op("cnt0",       SRA, 16'hA5A5, 4'd0,  16'hA5A5, 1);

        // backpressure with a competing operand held on the input
        wait_rdy("bp");
        bus.out_rdy = 1'b0;
        bus.In      = 16'h0001;
        bus.Cnt     = 4'd4;
        bus.Op      = SLL;
        bus.in_vld  = 1'b1;
        tick();
        bus.In  = 16'h1111;
        bus.Cnt = 4'd0;
        tick();
        chk("bp_vld", 32'(bus.out_vld), 32'd1);
        chk("bp_out", 32'(bus.Out), 32'h0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", {29'd0, bus.out_vld, bus.in_rdy, 1'b0}, 32'b100);
            chk("bp_stable", 32'(bus.Out), 32'h0010);
        end
        bus.out_rdy = 1'b1;
        tick();
        chk("bp_release", {30'd0, bus.in_rdy, bus.out_vld}, 32'b10);
        tick();
        bus.in_vld = 1'b0;
        chk("bp_new_vld", 32'(bus.out_vld), 32'd1);
        chk("bp_new_out", 32'(bus.Out), 32'h1111);
        tick();

        // asynchronous reset in the second SHIFT cycle
        wait_rdy("arst");
        bus.In     = 16'h8000;
        bus.Cnt    = 4'd15;
        bus.Op     = SRA;
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        tick();
        chk("arst_pre", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctl", {29'd0, bus.out_vld, bus.busy, bus.in_rdy}, 32'b001);
        chk("arst_out", 32'(bus.Out), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op("post_rst",   SLL, 16'h0003, 4'd2,  16'h000C, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
